// File: rtl/bht_update_queue.sv
// bht_update_queue: FIFO of resolved conditional-branch outcomes, replayed one
// per cycle into the BHT update port whenever that port is free. The branch
// unit cannot stall, so a resolution that arrives while the queue is full and
// nothing drains is dropped and counted in a saturating counter.
module bht_update_queue #(
  parameter int VLEN  = 64,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic                     res_valid_i,
  input  logic [VLEN-1:0]          res_pc_i,
  input  logic                     res_taken_i,
  output logic                     bht_valid_o,
  output logic [VLEN-1:0]          bht_pc_o,
  output logic                     bht_taken_o,
  input  logic                     bht_ready_i,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic [CNT_W-1:0]         drop_cnt_o
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;

  typedef struct packed {
    logic [VLEN-1:0] pc;
    logic            taken;
  } entry_t;

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [PTR_W-1:0] count;
  logic [CNT_W-1:0] drop_cnt;
  logic             non_empty;
  logic             pop;
  logic             push;
  logic             drop;
  entry_t           head_entry;

  // Pointers wrap modulo 2*DEPTH, so the difference is the occupancy and the
  // extra MSB tells a full queue apart from an empty one.
  assign count     = tail - head;
  assign non_empty = (count != '0);

  // Push/pop/drop decisions for this cycle; a pop frees a slot for a push in
  // the same cycle, and flush suppresses everything, including drop counting.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    pop  = 1'b0;
    push = 1'b0;
    drop = 1'b0;
    if (!flush_i) begin
      pop = non_empty && bht_ready_i;
      if (res_valid_i) begin
        if ((count == PTR_W'(DEPTH)) && !pop) drop = 1'b1;
        else                                 push = 1'b1;
      end
    end
  end

  // Head/tail pointer update; flush returns both to zero.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (!rst_ni) begin
      head <= '0;
      tail <= '0;
    end else if (flush_i) begin
      head <= '0;
      tail <= '0;
    end else begin
      if (pop)  head <= head + PTR_W'(1);
      if (push) tail <= tail + PTR_W'(1);
    end
  end

  // Entry storage; written at the tail slot on an accepted push.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      // NOTE: the storage array is deliberately reset so no stale branch data
      // survives reset; this forces flops rather than a RAM macro.
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push) begin
      mem[tail[IDX_W-1:0]] <= '{pc: res_pc_i, taken: res_taken_i};
    end
  end

  // Saturating drop counter; flush does not clear it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                     drop_cnt <= '0;
    else if (drop && drop_cnt != '1) drop_cnt <= drop_cnt + CNT_W'(1);
  end

  // Outputs come from registered state only; an empty queue presents zeros.
  assign head_entry  = non_empty ? mem[head[IDX_W-1:0]] : '0;
  assign bht_valid_o = non_empty;
  assign bht_pc_o    = head_entry.pc;
  assign bht_taken_o = head_entry.taken;
  assign count_o     = count;
  assign drop_cnt_o  = drop_cnt;

endmodule

// File: tb/tb_bht_update_queue.sv
// Self-checking bench for bht_update_queue: directed scenarios plus random
// traffic, all compared against a queue-based reference model.
module tb_bht_update_queue;

  localparam int VLEN  = 64;
  localparam int DEPTH = 4;
  localparam int CNT_W = 16;

  logic             clk;
  logic             rst_n;
  logic             flush;
  logic             res_valid;
  logic [VLEN-1:0]  res_pc;
  logic             res_taken;
  logic             bht_valid;
  logic [VLEN-1:0]  bht_pc;
  logic             bht_taken;
  logic             bht_ready;
  logic [2:0]       count;
  logic [CNT_W-1:0] drop_cnt;

  typedef struct {
    logic [VLEN-1:0] pc;
    logic            taken;
  } item_t;

  item_t model_q[$];
  int    model_drops;
  int    n_checks;
  int    n_errors;

  bht_update_queue #(.VLEN(VLEN), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .flush_i    (flush),
    .res_valid_i(res_valid),
    .res_pc_i   (res_pc),
    .res_taken_i(res_taken),
    .bht_valid_o(bht_valid),
    .bht_pc_o   (bht_pc),
    .bht_taken_o(bht_taken),
    .bht_ready_i(bht_ready),
    .count_o    (count),
    .drop_cnt_o (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Compare every observable output with the reference model.
  task automatic compare_all(input string tag);
    logic [63:0] exp_pc;
    logic        exp_tk;
    exp_pc = (model_q.size() != 0) ? model_q[0].pc : '0;
    exp_tk = (model_q.size() != 0) ? model_q[0].taken : 1'b0;
    check({tag, "_valid"}, bht_valid, 64'(model_q.size() != 0));
    check({tag, "_pc"},    bht_pc,    exp_pc);
    check({tag, "_taken"}, bht_taken, 64'(exp_tk));
    check({tag, "_count"}, count,     64'(model_q.size()));
    check({tag, "_drops"}, drop_cnt,  64'(model_drops));
  endtask

  // One clock cycle: drive inputs, confirm they do not leak combinationally,
  // advance the model at the edge, then compare on the falling edge.
  task automatic step(input logic v, input logic [63:0] pc, input logic tk,
                      input logic rdy, input logic fl, input string tag);
    bit pop_now;
    res_valid = v;
    res_pc    = pc;
    res_taken = tk;
    bht_ready = rdy;
    flush     = fl;
    #1;
    check({tag, "_nocomb"}, bht_valid, 64'(model_q.size() != 0));
    @(posedge clk);
    pop_now = (model_q.size() != 0) && rdy;
    if (fl) begin
      model_q.delete();
    end else begin
      if (pop_now) void'(model_q.pop_front());
      if (v) begin
        if (model_q.size() < DEPTH) model_q.push_back('{pc: pc, taken: tk});
        else if (model_drops < 65535) model_drops++;
      end
    end
    @(negedge clk);
    compare_all(tag);
  endtask

  initial begin
    logic [63:0] saved_drops;
    n_checks    = 0;
    n_errors    = 0;
    model_drops = 0;
    rst_n       = 1'b0;
    flush       = 1'b0;
    res_valid   = 1'b0;
    res_pc      = '0;
    res_taken   = 1'b0;
    bht_ready   = 1'b0;

    // Reset state before any clock edge.
    #1;
    compare_all("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    compare_all("post_reset");

    // Single push, held until ready rises.
    step(1, 64'h8000_0040, 1, 0, 0, "single_push");
    check("single_pc_const",  bht_pc,    64'h8000_0040);
    check("single_tk_const",  bht_taken, 64'd1);
    check("single_cnt_const", count,     64'd1);
    step(0, 0, 0, 0, 0, "single_hold");
    step(0, 0, 0, 1, 0, "single_pop");
    check("single_empty_const", bht_valid, 64'd0);

    // Fill, overflow by one, then drain in order.
    for (int i = 0; i < DEPTH; i++) step(1, 64'h100 + 64'(4 * i), i[0], 0, 0, "fill");
    step(1, 64'h110, 1, 0, 0, "overflow");
    check("overflow_drop_const",  drop_cnt, 64'd1);
    check("overflow_count_const", count,    64'd4);
    for (int i = 0; i < DEPTH; i++) begin
      check("drain_order_const", bht_pc, 64'h100 + 64'(4 * i));
      step(0, 0, 0, 1, 0, "drain");
    end
    check("drain_empty_const", bht_valid, 64'd0);

    // Full queue with simultaneous push and pop.
    for (int i = 0; i < DEPTH; i++) step(1, 64'h300 + 64'(4 * i), 1, 0, 0, "fill2");
    step(1, 64'h200, 0, 1, 0, "full_pushpop");
    check("full_pushpop_count_const", count,    64'd4);
    check("full_pushpop_drop_const",  drop_cnt, 64'd1);
    for (int i = 0; i < DEPTH; i++) begin
      if (i == DEPTH - 1) check("pushpop_last_const", bht_pc, 64'h200);
      step(0, 0, 0, 1, 0, "drain2");
    end

    // Flush at count 3 with a simultaneous resolution and ready.
    for (int i = 0; i < 3; i++) step(1, 64'h500 + 64'(i), 0, 0, 0, "fill3");
    saved_drops = 64'(drop_cnt);
    step(1, 64'h400, 1, 1, 1, "flush");
    check("flush_count_const", count,     64'd0);
    check("flush_valid_const", bht_valid, 64'd0);
    check("flush_drops_kept",  drop_cnt,  saved_drops);
    step(0, 0, 0, 1, 0, "after_flush");

    // Random traffic, wrapping the pointers many times.
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 3) != 0), {32'h0, $urandom}, 1'($urandom),
           1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 40) == 0), "random");
    end

    // Stream with ready held high must never drop.
    saved_drops = 64'(drop_cnt);
    for (int i = 0; i < 32; i++) step(1, 64'h9000 + 64'(i), i[1], 1, 0, "stream");
    check("stream_no_drop", drop_cnt, saved_drops);
    for (int i = 0; i < DEPTH; i++) step(0, 0, 0, 1, 0, "stream_drain");

    // Saturate the drop counter.
    for (int i = 0; i < DEPTH; i++) step(1, 64'h700 + 64'(i), 0, 0, 0, "fill_sat");
    for (int i = 0; i < 65540; i++) step(1, 64'hDEAD, 1, 0, 0, "saturate");
    check("saturated_const", drop_cnt, 64'hFFFF);
    step(1, 64'hBEEF, 1, 0, 0, "sat_hold");
    check("sat_hold_const", drop_cnt, 64'hFFFF);

    // Asynchronous reset between edges.
    #2;
    rst_n = 1'b0;
    #1;
    check("async_drop_const",  drop_cnt,  64'd0);
    check("async_valid_const", bht_valid, 64'd0);
    check("async_count_const", count,     64'd0);
    model_q.delete();
    model_drops = 0;
    @(negedge clk);
    rst_n = 1'b1;
    step(0, 0, 0, 1, 0, "after_async");
    step(1, 64'hABC0, 1, 0, 0, "after_async_push");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
